// File: rtl/tp84_dl_pkg.sv
// Shared types for the ROM download bridge: FSM states, FIFO entry layout and
// the default start address of the BG tile region.
package tp84_dl_pkg;

  localparam logic [24:0] BG_BASE_DEF = 25'hC000;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } dl_state_t;

  typedef struct packed {
    logic [24:0] addr;
    logic [7:0]  data;
  } dl_entry_t;

endpackage

// File: rtl/dl_fifo.sv
// Small synchronous FIFO of download entries. A push is accepted when full
// only if a pop happens in the same cycle.
module dl_fifo
  import tp84_dl_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic      clk,
  input  logic      reset_n,
  input  logic      push_i,
  input  logic      pop_i,
  input  dl_entry_t wdata_i,
  output dl_entry_t rdata_o,
  output logic      full_o,
  output logic      empty_o
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = FIFO_DEPTH[AW:0];

  dl_entry_t     mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == DEPTH_C);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign rdata_o = mem_q[rd_ptr_q];

  // Storage array; payload only, so no reset is needed.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  // Pointers and occupancy count; depth is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/rom_dl_bridge.sv
// Bridges the data_io byte stream to two toggle-handshake SDRAM write ports,
// remaps the BG region into merged 16-bit words and owns rom_loaded/core_reset.
module rom_dl_bridge
  import tp84_dl_pkg::*;
#(
  parameter int          FIFO_DEPTH   = 4,
  parameter logic [24:0] BG_BASE      = BG_BASE_DEF,
  parameter int          BG_MERGE_BIT = 13
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ioctl_downl,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic        ext_reset,
  output logic        port1_req,
  input  logic        port1_ack,
  output logic [22:0] port1_a,
  output logic [1:0]  port1_ds,
  output logic [15:0] port1_d,
  output logic        port2_req,
  input  logic        port2_ack,
  output logic [22:0] port2_a,
  output logic [1:0]  port2_ds,
  output logic [15:0] port2_d,
  output logic        port_we,
  output logic        rom_loaded,
  output logic        core_reset,
  output logic        overflow
);

  dl_state_t   state_q, state_d;
  logic        p1_req_q, p1_req_d, p2_req_q, p2_req_d, use2_q, use2_d;
  logic [22:0] p1_a_q, p1_a_d, p2_a_q, p2_a_d;
  logic [1:0]  p1_ds_q, p1_ds_d, p2_ds_q, p2_ds_d;
  logic [15:0] p1_d_q, p1_d_d, p2_d_q, p2_d_d;
  logic        wr_prev_q, downl_prev_q, done_q, port_we_q;
  logic        rom_loaded_q, core_reset_q, overflow_q;

  logic        push, pop, full, empty, in_bg;
  dl_entry_t   wentry, head;
  logic [24:0] b;
  logic        unused_bits;

  // A new byte is the rising edge of the wr level while a download is active.
  assign push        = ioctl_wr & ~wr_prev_q & ioctl_downl;
  assign wentry      = '{addr: ioctl_addr, data: ioctl_dout};
  assign in_bg       = (head.addr >= BG_BASE);
  assign b           = head.addr - BG_BASE;
  assign unused_bits = ^{head.addr[24], b[24]};

  dl_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (wentry),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty)
  );

  // Issue FSM: pop one entry, load the port registers and toggle the request(s),
  // then hold everything stable until every toggled port has acknowledged.
  always_comb begin
    state_d  = state_q;
    pop      = 1'b0;
    p1_req_d = p1_req_q;
    p2_req_d = p2_req_q;
    use2_d   = use2_q;
    p1_a_d   = p1_a_q;
    p1_ds_d  = p1_ds_q;
    p1_d_d   = p1_d_q;
    p2_a_d   = p2_a_q;
    p2_ds_d  = p2_ds_q;
    p2_d_d   = p2_d_q;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop      = 1'b1;
          p1_a_d   = head.addr[23:1];
          p1_ds_d  = {head.addr[0], ~head.addr[0]};
          p1_d_d   = {head.data, head.data};
          p1_req_d = ~p1_req_q;
          use2_d   = in_bg;
          if (in_bg) begin
            p2_a_d   = {b[23:14], b[12:0]};
            p2_ds_d  = {b[BG_MERGE_BIT], ~b[BG_MERGE_BIT]};
            p2_d_d   = {head.data, head.data};
            p2_req_d = ~p2_req_q;
          end
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if ((port1_ack == p1_req_q) && (!use2_q || (port2_ack == p2_req_q)))
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state and SDRAM port registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      p1_req_q <= 1'b0;
      p2_req_q <= 1'b0;
      use2_q   <= 1'b0;
      p1_a_q   <= '0;
      p1_ds_q  <= '0;
      p1_d_q   <= '0;
      p2_a_q   <= '0;
      p2_ds_q  <= '0;
      p2_d_q   <= '0;
    end else begin
      state_q  <= state_d;
      p1_req_q <= p1_req_d;
      p2_req_q <= p2_req_d;
      use2_q   <= use2_d;
      p1_a_q   <= p1_a_d;
      p1_ds_q  <= p1_ds_d;
      p1_d_q   <= p1_d_d;
      p2_a_q   <= p2_a_d;
      p2_ds_q  <= p2_ds_d;
      p2_d_q   <= p2_d_d;
    end
  end

  // Edge history, sticky completion/overflow flags and the registered core reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_prev_q    <= 1'b0;
      downl_prev_q <= 1'b0;
      done_q       <= 1'b0;
      port_we_q    <= 1'b0;
      rom_loaded_q <= 1'b0;
      core_reset_q <= 1'b1;
      overflow_q   <= 1'b0;
    end else begin
      wr_prev_q    <= ioctl_wr;
      downl_prev_q <= ioctl_downl;
      done_q       <= done_q | (downl_prev_q & ~ioctl_downl);
      port_we_q    <= (state_q != IDLE) | ~empty | ioctl_downl;
      rom_loaded_q <= rom_loaded_q | (done_q & empty & (state_q == IDLE));
      core_reset_q <= ext_reset | ~rom_loaded_q | ioctl_downl;
      overflow_q   <= overflow_q | (push & full & ~pop);
    end
  end

  assign port1_req  = p1_req_q;
  assign port1_a    = p1_a_q;
  assign port1_ds   = p1_ds_q;
  assign port1_d    = p1_d_q;
  assign port2_req  = p2_req_q;
  assign port2_a    = p2_a_q;
  assign port2_ds   = p2_ds_q;
  assign port2_d    = p2_d_q;
  assign port_we    = port_we_q;
  assign rom_loaded = rom_loaded_q;
  assign core_reset = core_reset_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_rom_dl_bridge.sv
// Directed bench for rom_dl_bridge with a delayed ack loopback model per port.
module tb_rom_dl_bridge;

  logic        clk, reset_n;
  logic        ioctl_downl, ioctl_wr, ext_reset;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        port1_req, port1_ack, port2_req, port2_ack;
  logic [22:0] port1_a, port2_a;
  logic [1:0]  port1_ds, port2_ds;
  logic [15:0] port1_d, port2_d;
  logic        port_we, rom_loaded, core_reset, overflow;

  int checks = 0;
  int errors = 0;
  int dly1 = 3, dly2 = 3, c1, c2;
  int nlog = 0;
  logic        p1_prev = 1'b0;
  logic [22:0] log_a [64];
  logic [15:0] log_d [64];
  int L0, k;

  rom_dl_bridge dut (
    .clk(clk), .reset_n(reset_n), .ioctl_downl(ioctl_downl), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ext_reset(ext_reset),
    .port1_req(port1_req), .port1_ack(port1_ack), .port1_a(port1_a),
    .port1_ds(port1_ds), .port1_d(port1_d),
    .port2_req(port2_req), .port2_ack(port2_ack), .port2_a(port2_a),
    .port2_ds(port2_ds), .port2_d(port2_d),
    .port_we(port_we), .rom_loaded(rom_loaded), .core_reset(core_reset),
    .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SDRAM ack model: echo each port's req after a programmable number of cycles.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      port1_ack <= 1'b0; c1 <= 0;
    end else if (port1_req !== port1_ack) begin
      if (c1 >= dly1) begin port1_ack <= port1_req; c1 <= 0; end
      else c1 <= c1 + 1;
    end
  end

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      port2_ack <= 1'b0; c2 <= 0;
    end else if (port2_req !== port2_ack) begin
      if (c2 >= dly2) begin port2_ack <= port2_req; c2 <= 0; end
      else c2 <= c2 + 1;
    end
  end

  // Record every port1 write (request toggle) in issue order.
  always @(posedge clk) begin
    #1;
    if (reset_n && (port1_req !== p1_prev)) begin
      if (nlog < 64) begin
        log_a[nlog] = port1_a;
        log_d[nlog] = port1_d;
      end
      nlog = nlog + 1;
    end
    p1_prev = port1_req;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [24:0] a, input logic [7:0] d);
    ioctl_wr = 1'b1; ioctl_addr = a; ioctl_dout = d;
    tick(1);
    ioctl_wr = 1'b0;
    tick(1);
  endtask

  initial begin
    reset_n = 1'b1; ioctl_downl = 1'b0; ioctl_wr = 1'b0; ext_reset = 1'b0;
    ioctl_addr = '0; ioctl_dout = '0;
    #2 reset_n = 1'b0;
    tick(3);
    chk("rst_p1_req", port1_req, 0);
    chk("rst_p2_req", port2_req, 0);
    chk("rst_p1_a", port1_a, 0);
    chk("rst_port_we", port_we, 0);
    chk("rst_rom_loaded", rom_loaded, 0);
    chk("rst_core_reset", core_reset, 1);
    chk("rst_overflow", overflow, 0);
    reset_n = 1'b1;
    tick(2);

    // Bytes outside a download are ignored.
    send_byte(25'h50, 8'hEE);
    tick(3);
    chk("nodl_p1_req", port1_req, 0);
    chk("nodl_nlog", nlog, 0);

    // Test 1: single byte, wr held high for several cycles -> one write.
    dly1 = 3;
    ioctl_downl = 1'b1;
    tick(2);
    ioctl_wr = 1'b1; ioctl_addr = 25'h3; ioctl_dout = 8'h5A;
    tick(1);
    chk("t1_lat_early", port1_req, 0);
    tick(1);
    chk("t1_p1_req", port1_req, 1);
    chk("t1_p2_req", port2_req, 0);
    chk("t1_p1_a", port1_a, 23'h1);
    chk("t1_p1_ds", port1_ds, 2'b10);
    chk("t1_p1_d", port1_d, 16'h5A5A);
    tick(1);
    ioctl_wr = 1'b0;
    tick(10);
    chk("t1_one_write", nlog, 1);
    chk("t1_port_we", port_we, 1);
    chk("t1_core_reset", core_reset, 1);

    // Test 2: BG byte, FSM waits for the slower port2 ack.
    dly1 = 2; dly2 = 10;
    send_byte(25'hE005, 8'h77);
    chk("t2_p1_req", port1_req, 0);
    chk("t2_p2_req", port2_req, 1);
    chk("t2_p1_a", port1_a, 23'h7002);
    chk("t2_p2_a", port2_a, 23'h0005);
    chk("t2_p2_ds", port2_ds, 2'b10);
    chk("t2_p2_d", port2_d, 16'h7777);
    send_byte(25'h10, 8'h11);
    tick(4);
    chk("t2_still_wait", port1_req, 0);
    tick(15);
    chk("t2_next_req", port1_req, 1);
    chk("t2_next_a", port1_a, 23'h8);
    chk("t2_next_p2", port2_req, 1);
    tick(8);

    // BG boundary: BG_BASE-1 is port1 only, BG_BASE uses both ports.
    send_byte(25'hBFFF, 8'h01);
    chk("bnd_lo_p1_req", port1_req, 0);
    chk("bnd_lo_p2_req", port2_req, 1);
    chk("bnd_lo_p1_a", port1_a, 23'h5FFF);
    chk("bnd_lo_p1_ds", port1_ds, 2'b10);
    tick(8);
    send_byte(25'hC000, 8'h02);
    chk("bnd_hi_p1_req", port1_req, 1);
    chk("bnd_hi_p2_req", port2_req, 0);
    chk("bnd_hi_p1_a", port1_a, 23'h6000);
    chk("bnd_hi_p1_ds", port1_ds, 2'b01);
    chk("bnd_hi_p2_a", port2_a, 23'h0);
    chk("bnd_hi_p2_ds", port2_ds, 2'b01);
    chk("bnd_hi_p2_d", port2_d, 16'h0202);
    tick(16);
    chk("pre_ovf", overflow, 0);

    // Test 3: six back-to-back bytes against a stalled ack.
    dly1 = 50;
    L0 = nlog;
    for (int i = 0; i < 6; i++) send_byte(25'h100 + 25'(i), 8'hA0 + 8'(i));
    chk("t3_overflow", overflow, 1);
    for (k = 0; k < 400 && nlog < L0 + 5; k++) tick(1);
    chk("t3_reached5", nlog, L0 + 5);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t3_a%0d", i), log_a[L0 + i], 32'((25'h100 + 25'(i)) >> 1));
      chk($sformatf("t3_d%0d", i), log_d[L0 + i], {16'h0, 8'hA0 + 8'(i), 8'hA0 + 8'(i)});
    end
    tick(60);
    chk("t3_no_6th", nlog, L0 + 5);

    // Test 4: download ends with entries still queued.
    dly1 = 20;
    L0 = nlog;
    for (int i = 0; i < 4; i++) send_byte(25'h200 + 25'(i), 8'h30 + 8'(i));
    ioctl_downl = 1'b0;
    tick(1);
    chk("t4_not_yet", rom_loaded, 0);
    for (k = 0; k < 300 && !rom_loaded; k++) tick(1);
    chk("t4_rom_loaded", rom_loaded, 1);
    chk("t4_all_issued", nlog, L0 + 4);
    chk("t4_last_acked", port1_ack, port1_req);
    chk("t4_cr_still", core_reset, 1);
    tick(1);
    chk("t4_cr_fall", core_reset, 0);
    chk("t4_port_we", port_we, 0);
    ext_reset = 1'b1;
    tick(2);
    chk("ext_reset_cr", core_reset, 1);
    ext_reset = 1'b0;
    tick(2);
    chk("ext_release_cr", core_reset, 0);

    // Re-download keeps rom_loaded but reasserts core_reset.
    ioctl_downl = 1'b1;
    tick(2);
    chk("redl_cr", core_reset, 1);
    chk("redl_loaded", rom_loaded, 1);

    // Test 5: asynchronous reset while waiting for acks.
    dly1 = 30; dly2 = 30;
    send_byte(25'hC300, 8'h99);
    chk("t5_p1_req", port1_req, 1);
    chk("t5_p2_req", port2_req, 1);
    chk("t5_p2_a", port2_a, 23'h300);
    tick(3);
    #2 reset_n = 1'b0;
    #1;
    chk("t5_async_p1_req", port1_req, 0);
    chk("t5_async_p2_req", port2_req, 0);
    chk("t5_async_p1_a", port1_a, 0);
    chk("t5_async_p2_d", port2_d, 0);
    chk("t5_async_loaded", rom_loaded, 0);
    chk("t5_async_cr", core_reset, 1);
    chk("t5_async_we", port_we, 0);
    L0 = nlog;
    tick(2);
    reset_n = 1'b1;
    tick(10);
    chk("t5_idle_req", port1_req, 0);
    chk("t5_idle_nlog", nlog, L0);
    send_byte(25'h400, 8'h44);
    chk("t5_new_req", port1_req, 1);
    chk("t5_new_a", port1_a, 23'h200);
    chk("t5_new_d", port1_d, 16'h4444);
    tick(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
